// File: rtl/markov_predictor.sv
// Markov-chain opponent model for the rock-paper-scissors engine: learns how the
// player's last HIST moves predict the next one and plays the move that beats it.
module markov_predictor #(
  parameter int          HIST  = 1,
  parameter int          CNT_W = 8,
  parameter logic [15:0] SEED  = 16'hACE1
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       clear,
  input  logic       move_valid,
  input  logic [1:0] move_in,
  output logic       move_ready,
  output logic       choice_valid,
  output logic [1:0] choice,
  output logic [1:0] predicted,
  output logic       bad_move,
  output logic       busy
);

  localparam int               CTX_W     = 2 * HIST;
  localparam int               ROWS      = 4 ** HIST;
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;
  localparam logic [1:0]       WARM_FULL = 2'(HIST);

  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_UPD,
    S_PRED,
    S_OUT
  } state_t;

  state_t           state;
  logic [CTX_W:0]   row_ptr;   // top bit set once every row has been zeroed
  logic [CTX_W-1:0] history;
  logic [1:0]       warm;
  logic [15:0]      lfsr;
  logic [1:0]       move_q;

  logic [CNT_W-1:0] cnt_tab [ROWS][3];
  logic [CNT_W-1:0] row_cur [3];
  logic [CNT_W-1:0] row_upd [3];
  logic [1:0]       rand3;
  logic [1:0]       pred_c;
  logic [1:0]       choice_c;

  // The same row read serves both UPD (old context) and PRED (new context).
  // NOTE: every always_comb output gets a value on every path (defaults first), so no latches.
  always_comb begin
    for (int i = 0; i < 3; i++) begin
      row_cur[i] = cnt_tab[history][i];
    end
    for (int i = 0; i < 3; i++) begin
      row_upd[i] = (row_cur[move_q] == CNT_MAX) ? (row_cur[i] >> 1) : row_cur[i];
    end
    row_upd[move_q] = row_upd[move_q] + 1'b1;
  end

  always_comb begin
    rand3  = (lfsr[1:0] == 2'd3) ? 2'd0 : lfsr[1:0];
    pred_c = rand3;
    if (warm == WARM_FULL) begin
      if (row_cur[0] > row_cur[1] && row_cur[0] > row_cur[2])      pred_c = 2'd0;
      else if (row_cur[1] > row_cur[0] && row_cur[1] > row_cur[2]) pred_c = 2'd1;
      else if (row_cur[2] > row_cur[0] && row_cur[2] > row_cur[1]) pred_c = 2'd2;
      else if (row_cur[0] == row_cur[1] && row_cur[1] == row_cur[2]) pred_c = rand3;
      else if (row_cur[0] == row_cur[1]) pred_c = lfsr[0] ? 2'd1 : 2'd0;
      else if (row_cur[0] == row_cur[2]) pred_c = lfsr[0] ? 2'd2 : 2'd0;
      else                               pred_c = lfsr[0] ? 2'd2 : 2'd1;
    end
    choice_c = (pred_c == 2'd2) ? 2'd0 : pred_c + 2'd1;
  end

  // NOTE: the table has no reset; INIT zeroes it one row per cycle so it can map to RAM.
  always_ff @(posedge clock) begin
    if (state == S_INIT && !row_ptr[CTX_W]) begin
      for (int i = 0; i < 3; i++) cnt_tab[row_ptr[CTX_W-1:0]][i] <= '0;
    end else if (state == S_UPD && warm == WARM_FULL) begin
      for (int i = 0; i < 3; i++) cnt_tab[history][i] <= row_upd[i];
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every block sees pre-edge values.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state        <= S_INIT;
      row_ptr      <= '0;
      history      <= '0;
      warm         <= '0;
      lfsr         <= SEED;
      move_q       <= '0;
      move_ready   <= 1'b0;
      choice_valid <= 1'b0;
      choice       <= '0;
      predicted    <= '0;
      bad_move     <= 1'b0;
      busy         <= 1'b0;
    end else begin
      lfsr         <= {lfsr[14:0], lfsr[15] ^ lfsr[13] ^ lfsr[12] ^ lfsr[10]};
      choice_valid <= 1'b0;
      bad_move     <= 1'b0;
      if (clear) begin
        state      <= S_INIT;
        row_ptr    <= '0;
        history    <= '0;
        warm       <= '0;
        move_ready <= 1'b0;
        busy       <= 1'b1;
      end else begin
        unique case (state)
          S_INIT: begin
            if (row_ptr[CTX_W]) begin
              state      <= S_IDLE;
              busy       <= 1'b0;
              move_ready <= 1'b1;
            end else begin
              row_ptr <= row_ptr + 1'b1;
              busy    <= 1'b1;
            end
          end
          S_IDLE: begin
            if (move_valid && move_ready) begin
              if (move_in == 2'd3) begin
                bad_move <= 1'b1;
              end else begin
                move_q     <= move_in;
                move_ready <= 1'b0;
                state      <= S_UPD;
              end
            end
          end
          S_UPD: begin
            history <= CTX_W'({history, move_q});
            if (warm != WARM_FULL) warm <= warm + 2'd1;
            state <= S_PRED;
          end
          S_PRED: begin
            predicted    <= pred_c;
            choice       <= choice_c;
            choice_valid <= 1'b1;
            state        <= S_OUT;
          end
          S_OUT: begin
            move_ready <= 1'b1;
            state      <= S_IDLE;
          end
          default: state <= S_INIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_markov_predictor.sv
// Bench for markov_predictor: directed scenarios plus random moves, every output
// checked against a count-table model of the opponent.
module tb_markov_predictor;

  localparam int          HIST  = 1;
  localparam int          CNT_W = 3;
  localparam int          ROWS  = 4 ** HIST;
  localparam int          CMAX  = (1 << CNT_W) - 1;
  localparam logic [15:0] SEED  = 16'hACE1;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       clear = 1'b0;
  logic       move_valid = 1'b0;
  logic [1:0] move_in = 2'd0;
  logic       move_ready, choice_valid, bad_move, busy;
  logic [1:0] choice, predicted;

  int total = 0;
  int bad   = 0;

  int          tab [ROWS][3];
  int          hist_q [$];
  int          warm;
  logic [15:0] m_lfsr, m_lfsr_prev;

  markov_predictor #(.HIST(HIST), .CNT_W(CNT_W), .SEED(SEED)) dut (
    .clock       (clock),
    .reset       (reset),
    .clear       (clear),
    .move_valid  (move_valid),
    .move_in     (move_in),
    .move_ready  (move_ready),
    .choice_valid(choice_valid),
    .choice      (choice),
    .predicted   (predicted),
    .bad_move    (bad_move),
    .busy        (busy)
  );

  always #5 clock = ~clock;

  function automatic logic [15:0] lfsr_step(input logic [15:0] x);
    return {x[14:0], ^(x & 16'hB400)};
  endfunction

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      m_lfsr      <= SEED;
      m_lfsr_prev <= SEED;
    end else begin
      m_lfsr_prev <= m_lfsr;
      m_lfsr      <= lfsr_step(m_lfsr);
    end
  end

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    foreach (tab[i, j]) tab[i][j] = 0;
    hist_q.delete();
    warm = 0;
  endtask

  function automatic int model_ctx();
    int c = 0;
    for (int i = 0; i < HIST; i++)
      if (i < hist_q.size()) c += hist_q[i] * (4 ** i);
    return c;
  endfunction

  task automatic model_learn(input int m);
    int c;
    if (warm == HIST) begin
      c = model_ctx();
      if (tab[c][m] == CMAX)
        for (int i = 0; i < 3; i++) tab[c][i] = tab[c][i] / 2;
      tab[c][m] = tab[c][m] + 1;
    end
    hist_q.push_front(m);
    if (hist_q.size() > HIST) void'(hist_q.pop_back());
    if (warm < HIST) warm++;
  endtask

  function automatic int pick3(input logic [15:0] l);
    int v = int'(l[1:0]);
    return (v == 3) ? 0 : v;
  endfunction

  function automatic int model_predict(input logic [15:0] l);
    int c, mx;
    int idx [$];
    if (warm < HIST) return pick3(l);
    c  = model_ctx();
    mx = tab[c][0];
    for (int i = 1; i < 3; i++) if (tab[c][i] > mx) mx = tab[c][i];
    for (int i = 0; i < 3; i++) if (tab[c][i] == mx) idx.push_back(i);
    if (idx.size() == 1) return idx[0];
    if (idx.size() == 2) return l[0] ? idx[1] : idx[0];
    return pick3(l);
  endfunction

  task automatic wait_ready(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clock);
      if (move_ready) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) check("ready_timeout", move_ready, 1);
  endtask

  task automatic init_check();
    int  n = 0;
    bit  up = 1'b0;
    for (int i = 0; i < 40 && !up; i++) begin
      @(negedge clock);
      if (busy) n++;
      if (move_ready) up = 1'b1;
    end
    check("init_busy_cycles", n, ROWS);
    check("init_ready", move_ready, 1);
    check("init_busy_off", busy, 0);
  endtask

  task automatic send_move(input int m, output int p);
    bit ok;
    int exp;
    p = -1;
    wait_ready(ok);
    if (!ok) return;
    move_valid = 1'b1;
    move_in    = m[1:0];
    @(posedge clock);
    @(negedge clock);
    if (m == 3) begin
      move_valid = 1'b0;
      check("bad_pulse", bad_move, 1);
      check("bad_no_choice", choice_valid, 0);
      check("bad_still_ready", move_ready, 1);
      @(negedge clock);
      check("bad_pulse_end", bad_move, 0);
      check("bad_no_choice_late", choice_valid, 0);
    end else begin
      model_learn(m);
      check("upd_no_choice", choice_valid, 0);
      check("upd_not_ready", move_ready, 0);
      check("upd_no_bad", bad_move, 0);
      move_in = 2'($urandom_range(0, 3));
      @(negedge clock);
      check("pred_no_choice", choice_valid, 0);
      check("pred_not_ready", move_ready, 0);
      @(negedge clock);
      move_valid = 1'b0;
      check("out_choice_valid", choice_valid, 1);
      exp = model_predict(m_lfsr_prev);
      check("predicted", predicted, exp);
      check("choice", choice, (exp + 1) % 3);
      p = int'(predicted);
      @(negedge clock);
      check("out_pulse_end", choice_valid, 0);
      check("back_to_idle", move_ready, 1);
    end
  endtask

  task automatic clear_in_pred(input int m);
    bit ok;
    int seen = 0;
    wait_ready(ok);
    if (!ok) return;
    move_valid = 1'b1;
    move_in    = m[1:0];
    @(posedge clock);
    @(negedge clock);
    move_valid = 1'b0;
    @(negedge clock);
    clear = 1'b1;
    @(negedge clock);
    clear = 1'b0;
    check("clr_no_choice", choice_valid, 0);
    check("clr_busy", busy, 1);
    model_clear();
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (choice_valid) seen++;
      if (move_ready) break;
    end
    check("clr_silent", seen, 0);
    check("clr_ready_again", move_ready, 1);
  endtask

  task automatic reset_in_upd(input int m);
    bit ok;
    wait_ready(ok);
    if (!ok) return;
    move_valid = 1'b1;
    move_in    = m[1:0];
    @(posedge clock);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_outputs", {move_ready, choice_valid, choice, predicted, bad_move, busy}, 0);
    move_valid = 1'b0;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    model_clear();
    init_check();
  endtask

  initial begin
    int p, m;
    model_clear();
    repeat (3) @(negedge clock);
    check("reset_outputs", {move_ready, choice_valid, choice, predicted, bad_move, busy}, 0);
    reset = 1'b0;
    init_check();

    for (int i = 0; i < 5; i++) send_move(0, p);
    check("rock5_pred", p, 0);
    check("rock5_choice_hold", choice, 1);

    for (int i = 0; i < 20; i++) begin
      send_move(0, p);
      if (i >= 10) check("alt_ctx_rock", p, 1);
      send_move(1, p);
      if (i >= 10) check("alt_ctx_paper", p, 0);
    end

    send_move(3, p);
    send_move(0, p);

    clear_in_pred(2);

    // Build row R = {7,2,5}, then one more R triggers halving.
    send_move(0, p);
    repeat (7) send_move(0, p);
    repeat (2) begin send_move(1, p); send_move(0, p); end
    repeat (5) begin send_move(2, p); send_move(0, p); end
    send_move(0, p);
    check("halve_pred", p, 0);
    repeat (3) begin send_move(2, p); send_move(0, p); end
    check("halve_after_pred", p, 2);

    for (int i = 0; i < 120; i++) begin
      repeat ($urandom_range(0, 2)) @(negedge clock);
      m = ($urandom_range(0, 7) == 0) ? 3 : int'($urandom_range(0, 2));
      send_move(m, p);
    end

    reset_in_upd(1);
    for (int i = 0; i < 8; i++) send_move(int'($urandom_range(0, 2)), p);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
